// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared default widths, burst type, FSM state and grant encodings
package mem_port_arbiter_pkg;
  localparam int DEF_ADD_WIDTH = 32;
  localparam int DEF_ADD_ID_WIDTH = 4;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_BURST_SIZE = 3;
  localparam int DEF_BURST_TYPE = 2;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_BURST = 2'd2} state_t;
  typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} grant_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: write/read burst request handshakes (wr_*, rd_*) and per-beat memory handshake (mem_*); slave = arbiter side, master = requester/memory side
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int ADD_ID_WIDTH = DEF_ADD_ID_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int BURST_SIZE = DEF_BURST_SIZE,
  parameter int BURST_TYPE = DEF_BURST_TYPE
);
  logic wr_valid_in;
  logic wr_ready_out;
  logic [ADD_WIDTH-1:0] wr_addr_in;
  logic [ADD_ID_WIDTH-1:0] wr_id_in;
  logic [BURST_LEN-1:0] wr_len_in;
  logic [BURST_SIZE-1:0] wr_size_in;
  logic [BURST_TYPE-1:0] wr_burst_in;
  logic rd_valid_in;
  logic rd_ready_out;
  logic [ADD_WIDTH-1:0] rd_addr_in;
  logic [ADD_ID_WIDTH-1:0] rd_id_in;
  logic [BURST_LEN-1:0] rd_len_in;
  logic [BURST_SIZE-1:0] rd_size_in;
  logic [BURST_TYPE-1:0] rd_burst_in;
  logic mem_valid_out;
  logic mem_ready_in;
  logic [ADD_WIDTH-1:0] mem_addr_out;
  logic [ADD_ID_WIDTH-1:0] mem_id_out;
  logic mem_we_out;
  logic mem_last_out;
  modport slave (
    input wr_valid_in, wr_addr_in, wr_id_in, wr_len_in, wr_size_in, wr_burst_in,
    input rd_valid_in, rd_addr_in, rd_id_in, rd_len_in, rd_size_in, rd_burst_in,
    input mem_ready_in,
    output wr_ready_out, rd_ready_out,
    output mem_valid_out, mem_addr_out, mem_id_out, mem_we_out, mem_last_out
  );
  modport master (
    output wr_valid_in, wr_addr_in, wr_id_in, wr_len_in, wr_size_in, wr_burst_in,
    output rd_valid_in, rd_addr_in, rd_id_in, rd_len_in, rd_size_in, rd_burst_in,
    output mem_ready_in,
    input wr_ready_out, rd_ready_out,
    input mem_valid_out, mem_addr_out, mem_id_out, mem_we_out, mem_last_out
  );
endinterface

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: combinational next beat address (in: addr, size, len, burst; out: next_addr) for FIXED/INCR/WRAP bursts
module burst_addr_gen
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int BURST_SIZE = DEF_BURST_SIZE,
  parameter int BURST_TYPE = DEF_BURST_TYPE
) (
  input  logic [ADD_WIDTH-1:0]  addr,
  input  logic [BURST_SIZE-1:0] size,
  input  logic [BURST_LEN-1:0]  len,
  input  logic [BURST_TYPE-1:0] burst,
  output logic [ADD_WIDTH-1:0]  next_addr
);
  logic [ADD_WIDTH-1:0] step;
  logic [ADD_WIDTH-1:0] mask;
  logic [ADD_WIDTH-1:0] incr;
  logic wrap;
  // wrap region is (len+1)<<size bytes; only power-of-two beat counts wrap, anything else (and reserved type) steps like INCR
  always_comb begin
    step = ADD_WIDTH'(1) << size;
    mask = ((ADD_WIDTH'(len) + ADD_WIDTH'(1)) << size) - ADD_WIDTH'(1);
    incr = addr + step;
    wrap = burst == BURST_TYPE'(BURST_WRAP) && (len == BURST_LEN'(1) || len == BURST_LEN'(3) ||
           len == BURST_LEN'(7) || len == BURST_LEN'(15));
    next_addr = burst == BURST_TYPE'(BURST_FIXED) ? addr : wrap ? (addr & ~mask) | (incr & mask) : incr;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin write/read burst arbiter onto a single-port memory; ports clk, reset, bus (mem_port_arbiter_if.slave)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int ADD_ID_WIDTH = DEF_ADD_ID_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int BURST_SIZE = DEF_BURST_SIZE,
  parameter int BURST_TYPE = DEF_BURST_TYPE
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  state_t state;
  grant_t last_grant;
  logic [BURST_LEN-1:0] beat_cnt;
  logic [BURST_LEN-1:0] beat_nxt;
  logic [BURST_LEN-1:0] len_q;
  logic [BURST_SIZE-1:0] size_q;
  logic [BURST_TYPE-1:0] burst_q;
  logic [ADD_WIDTH-1:0] next_addr;
  logic wr_sel;
  logic rd_sel;
  assign wr_sel = bus.wr_valid_in & (~bus.rd_valid_in | last_grant == GNT_READ);
  assign rd_sel = bus.rd_valid_in & (~bus.wr_valid_in | last_grant == GNT_WRITE);
  assign bus.wr_ready_out = state == IDLE & ~reset & wr_sel;
  assign bus.rd_ready_out = state == IDLE & ~reset & rd_sel;
  assign beat_nxt = beat_cnt + BURST_LEN'(1);
  burst_addr_gen #(
    .ADD_WIDTH(ADD_WIDTH),
    .BURST_LEN(BURST_LEN),
    .BURST_SIZE(BURST_SIZE),
    .BURST_TYPE(BURST_TYPE)
  ) u_addr_gen (
    .addr(bus.mem_addr_out),
    .size(size_q),
    .len(len_q),
    .burst(burst_q),
    .next_addr(next_addr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= GNT_READ;
      beat_cnt <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      bus.mem_valid_out <= 1'b0;
      bus.mem_we_out <= 1'b0;
      bus.mem_last_out <= 1'b0;
      bus.mem_addr_out <= '0;
      bus.mem_id_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_ready_out) begin
            state <= WR_BURST;
            last_grant <= GNT_WRITE;
            beat_cnt <= '0;
            len_q <= bus.wr_len_in;
            size_q <= bus.wr_size_in;
            burst_q <= bus.wr_burst_in;
            bus.mem_valid_out <= 1'b1;
            bus.mem_we_out <= 1'b1;
            bus.mem_last_out <= bus.wr_len_in == '0;
            bus.mem_addr_out <= bus.wr_addr_in;
            bus.mem_id_out <= bus.wr_id_in;
          end else if (bus.rd_ready_out) begin
            state <= RD_BURST;
            last_grant <= GNT_READ;
            beat_cnt <= '0;
            len_q <= bus.rd_len_in;
            size_q <= bus.rd_size_in;
            burst_q <= bus.rd_burst_in;
            bus.mem_valid_out <= 1'b1;
            bus.mem_we_out <= 1'b0;
            bus.mem_last_out <= bus.rd_len_in == '0;
            bus.mem_addr_out <= bus.rd_addr_in;
            bus.mem_id_out <= bus.rd_id_in;
          end
        end
        WR_BURST, RD_BURST: begin
          if (bus.mem_ready_in) begin
            if (bus.mem_last_out) begin
              state <= IDLE;
              bus.mem_valid_out <= 1'b0;
              bus.mem_we_out <= 1'b0;
              bus.mem_last_out <= 1'b0;
            end else begin
              beat_cnt <= beat_nxt;
              bus.mem_addr_out <= next_addr;
              bus.mem_last_out <= beat_nxt == len_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
